// File: rtl/bitbrick_mac.sv
// bitbrick_mac: temporally fused, precision-scalable multiply-accumulate.
// A P-bit x P-bit product (P = 2/4/8/16) is split into 2-bit digit
// products. One digit product is evaluated per cycle, shifted into place
// and added to a wide wrapping accumulator. Operands and results use
// valid/ready handshakes.
// Optional build macro: BB_ZERO_SKIP_EN. When it is defined, an operation
// whose A or B operand is zero in its low P bits spends a single compute
// cycle and adds nothing to the accumulator.
module bitbrick_mac #(
  parameter int MAX_BITS  = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_BITS-1:0]  a,
  input  logic [MAX_BITS-1:0]  b,
  input  logic [1:0]           prec,
  input  logic [1:0]           sel,
  input  logic                 in_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  // Widest precision code the instance supports; larger codes clamp to it.
  localparam logic [1:0] MAX_CODE = (MAX_BITS >= 16) ? 2'd3 :
                                    (MAX_BITS >= 8)  ? 2'd2 :
                                    (MAX_BITS >= 4)  ? 2'd1 : 2'd0;

  state_e                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [MAX_BITS-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]            pl_q, pl_d;   // log2 of the digit count N
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            prec_clamped;

  // Digit-level datapath signals for the current (i, j) pair.
  logic [7:0]            digit_mask;
  logic [7:0]            k_last;
  logic [3:0]            i_idx, j_idx, n_last;
  logic [1:0]            a_dig, b_dig;
  logic                  a_sgn, b_sgn;
  logic signed [2:0]     da, db;
  logic signed [5:0]     prod;
  logic [ACC_WIDTH-1:0]  pp_ext;
  logic [5:0]            shamt;
  logic [4:0]            ij_sum;

`ifdef BB_ZERO_SKIP_EN
  logic skip_q, skip_d;

  // All-ones mask covering the low P bits for a clamped precision code.
  function automatic logic [MAX_BITS-1:0] low_mask(input logic [1:0] pl);
    low_mask = MAX_BITS'((64'd1 << (2 << pl)) - 64'd1);
  endfunction
`else
  logic skip_q;
  assign skip_q = 1'b0;
`endif

  assign prec_clamped = (prec > MAX_CODE) ? MAX_CODE : prec;

  // Decode the digit counter into (i, j) and build the shifted partial product.
  always_comb begin
    digit_mask = 8'((32'd1 << pl_q) - 32'd1);
    k_last     = 8'((32'd1 << {pl_q, 1'b0}) - 32'd1);
    n_last     = 4'(digit_mask);
    i_idx      = 4'(cnt_q >> pl_q);
    j_idx      = 4'(cnt_q & digit_mask);
    a_dig      = 2'(a_q >> {i_idx, 1'b0});
    b_dig      = 2'(b_q >> {j_idx, 1'b0});
    // Only the most significant digit carries the sign of a signed operand.
    a_sgn      = (i_idx == n_last) && (sel_q == 2'b00 || sel_q == 2'b10);
    b_sgn      = (j_idx == n_last) && (sel_q == 2'b00);
    da         = {a_sgn & a_dig[1], a_dig};
    db         = {b_sgn & b_dig[1], b_dig};
    prod       = 6'(da) * 6'(db);
    pp_ext     = ACC_WIDTH'(prod);
    ij_sum     = 5'(i_idx) + 5'(j_idx);
    shamt      = {ij_sum, 1'b0};
  end

  // Next-state and datapath updates for the IDLE -> COMPUTE -> DONE cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pl_d    = pl_q;
    sel_d   = sel_q;
`ifdef BB_ZERO_SKIP_EN
    skip_d  = skip_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          pl_d    = prec_clamped;
          sel_d   = sel;
          cnt_d   = '0;
          acc_d   = in_acc ? acc_q : '0;
`ifdef BB_ZERO_SKIP_EN
          skip_d  = ((a & low_mask(prec_clamped)) == '0) ||
                    ((b & low_mask(prec_clamped)) == '0);
`endif
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (skip_q) begin
          state_d = DONE;
        end else begin
          acc_d = acc_q + (pp_ext << shamt);
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == k_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; acc survives the result handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pl_q    <= '0;
      sel_q   <= '0;
`ifdef BB_ZERO_SKIP_EN
      skip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pl_q    <= pl_d;
      sel_q   <= sel_d;
`ifdef BB_ZERO_SKIP_EN
      skip_q  <= skip_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;

endmodule
